// File: rtl/oh_memory_dp.sv
// Behavioural dual-port RAM: bit-masked synchronous write port, registered read port.
// BIST inputs take over the write port; shutdown blocks both ports.
module oh_memory_dp #(
  parameter int DW    = 104,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          wr_clk,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_wem,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_din,
  input  logic          rd_clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dout,
  input  logic          shutdown,
  input  logic          memconfig,
  input  logic          bist_en,
  input  logic          bist_we,
  input  logic [DW-1:0] bist_wem,
  input  logic [AW-1:0] bist_addr,
  input  logic [DW-1:0] bist_din
);

  logic [DW-1:0] mem [DEPTH];

  logic          w_en;
  logic [DW-1:0] w_wem;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_din;

  always_comb begin
    w_en   = wr_en;
    w_wem  = wr_wem;
    w_addr = wr_addr;
    w_din  = wr_din;
    if (bist_en) begin
      w_en   = bist_we;
      w_wem  = bist_wem;
      w_addr = bist_addr;
      w_din  = bist_din;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (w_en && !shutdown)
      mem[w_addr] <= (mem[w_addr] & ~w_wem) | (w_din & w_wem);
  end

  // memconfig=1 freezes the output register (hold mode)
  always_ff @(posedge rd_clk) begin
    if (rd_en && !shutdown && !memconfig)
      rd_dout <= mem[rd_addr];
  end

endmodule

// File: rtl/oh_fifo_sync_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, registered flags and error pulses
// around one oh_memory_dp instance. Read data is valid one cycle after an accepted read.
module oh_fifo_sync_ctrl #(
  parameter int DW        = 104,
  parameter int DEPTH     = 32,
  parameter int PROG_FULL = DEPTH - 4,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          prog_full,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          wr_overflow,
  output logic          rd_underflow
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] PF_LVL   = (AW+1)'(PROG_FULL);

  logic          wr_acc;
  logic          rd_acc;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_ptr_nxt;
  logic [AW:0]   rd_ptr_nxt;
  logic [AW:0]   count_nxt;

  // Occupancy is the modulo-2*DEPTH pointer distance; it equals the +1/-1/hold
  // count rule because pointers only move on accepted operations.
  always_comb begin
    wr_acc     = wr_en & ~full;
    rd_acc     = rd_en & ~empty;
    wr_ptr_nxt = wr_ptr + (AW+1)'(wr_acc);
    rd_ptr_nxt = rd_ptr + (AW+1)'(rd_acc);
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      prog_full    <= 1'b0;
      valid        <= 1'b0;
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == FULL_LVL);
      prog_full    <= (count_nxt >= PF_LVL);
      valid        <= rd_acc;
      wr_overflow  <= wr_en & full;
      rd_underflow <= rd_en & empty;
    end
  end

  oh_memory_dp #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .wr_clk    (clk),
    .wr_en     (wr_acc),
    .wr_wem    ('1),
    .wr_addr   (wr_ptr[AW-1:0]),
    .wr_din    (din),
    .rd_clk    (clk),
    .rd_en     (rd_acc),
    .rd_addr   (rd_ptr[AW-1:0]),
    .rd_dout   (dout),
    .shutdown  (1'b0),
    .memconfig (1'b0),
    .bist_en   (1'b0),
    .bist_we   (1'b0),
    .bist_wem  ('0),
    .bist_addr ('0),
    .bist_din  ('0)
  );

endmodule

// File: tb/tb_oh_fifo_sync_ctrl.sv
// Directed self-checking bench for oh_fifo_sync_ctrl (DW=104, DEPTH=32, PROG_FULL=28).
module tb_oh_fifo_sync_ctrl;

  localparam int DW    = 104;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          full;
  logic          prog_full;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          valid;
  logic          empty;
  logic [AW:0]   count;
  logic          wr_overflow;
  logic          rd_underflow;

  int vectors = 0;
  int miscompares = 0;

  oh_fifo_sync_ctrl #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .din          (din),
    .full         (full),
    .prog_full    (prog_full),
    .rd_en        (rd_en),
    .dout         (dout),
    .valid        (valid),
    .empty        (empty),
    .count        (count),
    .wr_overflow  (wr_overflow),
    .rd_underflow (rd_underflow)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", empty); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", full); end
    vectors++; if (prog_full !== 1'b0) begin miscompares++; $display("FAIL reset_prog_full got %b want 0", prog_full); end
    vectors++; if (count !== 6'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid); end
    vectors++; if (wr_overflow !== 1'b0 || rd_underflow !== 1'b0) begin
      miscompares++; $display("FAIL reset_pulses got %b%b want 00", wr_overflow, rd_underflow); end
  endtask

  task automatic test_underflow();
    rd_en = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      vectors++; if (rd_underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_pulse[%0d] got %b want 1", i, rd_underflow); end
      vectors++; if (count !== 6'd0) begin miscompares++; $display("FAIL underflow_count[%0d] got %0d want 0", i, count); end
      vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL underflow_valid[%0d] got %b want 0", i, valid); end
    end
    rd_en = 1'b0;
    tick();
    vectors++; if (rd_underflow !== 1'b0) begin miscompares++; $display("FAIL underflow_clear got %b want 0", rd_underflow); end
  endtask

  task automatic test_fill_drain();
    for (int unsigned i = 1; i <= 32; i++) begin
      wr_en = 1'b1; din = DW'(i);
      tick();
      vectors++; if (count !== 6'(i)) begin miscompares++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i); end
      vectors++; if (full !== (i == 32)) begin miscompares++; $display("FAIL fill_full[%0d] got %b want %b", i, full, i == 32); end
      vectors++; if (prog_full !== (i >= 28)) begin miscompares++; $display("FAIL fill_prog_full[%0d] got %b want %b", i, prog_full, i >= 28); end
      vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL fill_empty[%0d] got %b want 0", i, empty); end
    end
    wr_en = 1'b0;
    for (int unsigned i = 1; i <= 32; i++) begin
      rd_en = 1'b1;
      tick();
      vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL drain_valid[%0d] got %b want 1", i, valid); end
      vectors++; if (dout !== DW'(i)) begin miscompares++; $display("FAIL drain_dout[%0d] got %h want %h", i, dout, DW'(i)); end
      vectors++; if (count !== 6'(32 - i)) begin miscompares++; $display("FAIL drain_count[%0d] got %0d want %0d", i, count, 32 - i); end
      vectors++; if (empty !== (i == 32)) begin miscompares++; $display("FAIL drain_empty[%0d] got %b want %b", i, empty, i == 32); end
    end
    rd_en = 1'b0;
    tick();
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL drain_valid_drop got %b want 0", valid); end
  endtask

  task automatic test_full_rw();
    for (int unsigned i = 0; i < 32; i++) begin
      wr_en = 1'b1; din = DW'(32'h100 + i);
      tick();
    end
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fullrw_full_before got %b want 1", full); end
    wr_en = 1'b1; rd_en = 1'b1; din = DW'(32'hDEAD);
    tick();
    vectors++; if (wr_overflow !== 1'b1) begin miscompares++; $display("FAIL fullrw_overflow got %b want 1", wr_overflow); end
    vectors++; if (count !== 6'd31) begin miscompares++; $display("FAIL fullrw_count got %0d want 31", count); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL fullrw_full got %b want 0", full); end
    vectors++; if (valid !== 1'b1 || dout !== DW'(32'h100)) begin
      miscompares++; $display("FAIL fullrw_oldest got %b/%h want 1/100", valid, dout); end
    wr_en = 1'b0;
    for (int unsigned i = 1; i < 32; i++) begin
      tick();
      if (i == 1) begin
        vectors++; if (wr_overflow !== 1'b0) begin miscompares++; $display("FAIL fullrw_overflow_clear got %b want 0", wr_overflow); end
      end
      vectors++; if (dout !== DW'(32'h100 + i)) begin miscompares++; $display("FAIL fullrw_drain[%0d] got %h want %h", i, dout, DW'(32'h100 + i)); end
    end
    rd_en = 1'b0;
    tick();
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL fullrw_empty_end got %b want 1", empty); end
  endtask

  task automatic test_empty_rw();
    wr_en = 1'b1; rd_en = 1'b1; din = DW'(32'hAA);
    tick();
    vectors++; if (rd_underflow !== 1'b1) begin miscompares++; $display("FAIL emptyrw_underflow got %b want 1", rd_underflow); end
    vectors++; if (count !== 6'd1) begin miscompares++; $display("FAIL emptyrw_count got %0d want 1", count); end
    vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL emptyrw_empty got %b want 0", empty); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL emptyrw_valid got %b want 0", valid); end
    wr_en = 1'b0;
    tick();
    vectors++; if (valid !== 1'b1 || dout !== DW'(32'hAA)) begin
      miscompares++; $display("FAIL emptyrw_read got %b/%h want 1/aa", valid, dout); end
    vectors++; if (empty !== 1'b1 || rd_underflow !== 1'b0) begin
      miscompares++; $display("FAIL emptyrw_after got empty=%b unf=%b want 1/0", empty, rd_underflow); end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int unsigned i = 0; i < 5; i++) begin
      wr_en = 1'b1; din = DW'(32'h5000 + i);
      tick();
    end
    vectors++; if (count !== 6'd5) begin miscompares++; $display("FAIL b2b_prefill got %0d want 5", count); end
    rd_en = 1'b1;
    for (int unsigned k = 0; k < 100; k++) begin
      din = DW'(32'h5000 + k + 5);
      tick();
      vectors++; if (count !== 6'd5) begin miscompares++; $display("FAIL b2b_count[%0d] got %0d want 5", k, count); end
      vectors++; if (valid !== 1'b1 || dout !== DW'(32'h5000 + k)) begin
        miscompares++; $display("FAIL b2b_data[%0d] got %b/%h want 1/%h", k, valid, dout, DW'(32'h5000 + k)); end
      vectors++; if ({empty, full, prog_full, wr_overflow, rd_underflow} !== 5'b0) begin
        miscompares++; $display("FAIL b2b_flags[%0d] got %b want 00000", k, {empty, full, prog_full, wr_overflow, rd_underflow}); end
    end
    wr_en = 1'b0;
    for (int unsigned k = 100; k < 105; k++) begin
      tick();
      vectors++; if (dout !== DW'(32'h5000 + k)) begin miscompares++; $display("FAIL b2b_drain[%0d] got %h want %h", k, dout, DW'(32'h5000 + k)); end
    end
    rd_en = 1'b0;
    tick();
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL b2b_empty_end got %b want 1", empty); end
  endtask

  task automatic test_reset_midop();
    for (int unsigned i = 0; i < 10; i++) begin
      wr_en = 1'b1; din = DW'(32'h700 + i);
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    vectors++; if (valid !== 1'b1 || count !== 6'd9) begin
      miscompares++; $display("FAIL midop_inflight got %b/%0d want 1/9", valid, count); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL midop_valid got %b want 0", valid); end
    vectors++; if (empty !== 1'b1 || count !== 6'd0) begin
      miscompares++; $display("FAIL midop_clear got empty=%b count=%0d want 1/0", empty, count); end
    tick();
    rd_en = 1'b0;
    vectors++; if (valid !== 1'b0 || count !== 6'd0) begin
      miscompares++; $display("FAIL midop_held got %b/%0d want 0/0", valid, count); end
    reset = 1'b0;
    tick();
    wr_en = 1'b1; din = DW'(32'h5A);
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    vectors++; if (valid !== 1'b1 || dout !== DW'(32'h5A)) begin
      miscompares++; $display("FAIL midop_readback got %b/%h want 1/5a", valid, dout); end
    rd_en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_underflow();
    test_fill_drain();
    test_full_rw();
    test_empty_rw();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
